// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver. Synchronises rx, finds the start edge,
// samples every bit at its midpoint and publishes each good byte with a
// one-cycle po_flag strobe.
module uart_rx #(
   parameter int BAUD_CNT = 56
) (
   input  logic       sclk,
   input  logic       srst,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       po_flag
);

   localparam int CW = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;
   localparam logic [CW-1:0] BAUD_MAX   = CW'(BAUD_CNT - 1);
   localparam logic [CW-1:0] SAMPLE_PT  = CW'(BAUD_CNT / 2 - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic          rx_m_q, rx_s_q, rx_d_q;
   state_t        state_q, state_d;
   logic [CW-1:0] baud_q, baud_d;
   logic [3:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    data_q, data_d;
   logic          flag_q, flag_d;
   logic          fall;
   logic          sample;

   assign fall    = rx_d_q & ~rx_s_q;
   assign sample  = (baud_q == SAMPLE_PT);
   assign rx_data = data_q;
   assign po_flag = flag_q;

   // Two-flop synchroniser plus one delay flop for edge detection; idles high
   always_ff @(posedge sclk) begin
      if (srst) begin
         rx_m_q <= 1'b1;
         rx_s_q <= 1'b1;
         rx_d_q <= 1'b1;
      end else begin
         rx_m_q <= rx;
         rx_s_q <= rx_m_q;
         rx_d_q <= rx_s_q;
      end
   end

   // Next-state: frame FSM, bit/baud counters, shift register and output load
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      flag_d  = 1'b0;

      if (state_q == IDLE) begin
         baud_d = '0;
         bit_d  = '0;
      end else if (baud_q == BAUD_MAX) begin
         baud_d = '0;
         bit_d  = bit_q + 4'd1;
      end else begin
         baud_d = baud_q + CW'(1);
      end

      unique case (state_q)
         IDLE: begin
            if (fall) state_d = START;
         end
         START: begin
            if (sample) begin
               if (rx_s_q) begin
                  // Start bit did not survive to its midpoint: a glitch
                  state_d = IDLE;
                  baud_d  = '0;
                  bit_d   = '0;
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (sample) begin
               shift_d = {rx_s_q, shift_q[7:1]};
               if (bit_q == 4'd8) state_d = STOP;
            end
         end
         STOP: begin
            if (sample) begin
               // Leave at the stop midpoint so an immediately following start edge is seen
               if (rx_s_q) begin
                  data_d = shift_q;
                  flag_d = 1'b1;
               end
               state_d = IDLE;
               baud_d  = '0;
               bit_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge sclk) begin
      if (srst) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         flag_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         flag_q  <= flag_d;
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: reset, single byte with latency window,
// back-to-back frames, glitch rejection, framing error and mid-frame reset.
module tb_uart_rx;

   localparam int BAUD = 56;

   logic       sclk;
   logic       srst;
   logic       rx;
   logic [7:0] rx_data;
   logic       po_flag;

   int         total = 0;
   int         bad   = 0;
   int         cyc   = 0;
   int         npulse = 0;
   int         last_pulse_cyc = 0;
   logic [7:0] rxd [0:31];
   int         t0;
   int         base;

   uart_rx #(.BAUD_CNT(BAUD)) dut (
      .sclk    (sclk),
      .srst    (srst),
      .rx      (rx),
      .rx_data (rx_data),
      .po_flag (po_flag)
   );

   initial sclk = 1'b0;
   always #5 sclk = ~sclk;

   // Free-running cycle counter
   always @(posedge sclk) cyc <= cyc + 1;

   // Record every strobe and the byte presented with it
   always @(negedge sclk) begin
      if (po_flag) begin
         if (npulse < 32) rxd[npulse] = rx_data;
         npulse = npulse + 1;
         last_pulse_cyc = cyc;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) else begin
         bad = bad + 1;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      rx = b;
      repeat (BAUD) @(posedge sclk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(stop);
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(posedge sclk);
      #1;
   endtask

   initial begin
      srst = 1'b1;
      rx   = 1'b1;
      for (int i = 0; i < 32; i++) rxd[i] = 'x;

      // Reset
      repeat (10) @(posedge sclk);
      #1;
      check("reset_data", {24'd0, rx_data}, 32'h00);
      check("reset_flag", {31'd0, po_flag}, 32'd0);
      srst = 1'b0;
      idle(200);
      check("idle_no_pulse", npulse, 0);

      // Single byte 0x55 with latency window
      t0 = cyc;
      send_frame(8'h55, 1'b1);
      idle(20);
      check("single_pulses", npulse, 1);
      check("single_data", {24'd0, rxd[0]}, 32'h55);
      check("single_latency_ok",
            ((last_pulse_cyc - t0) >= 9 * BAUD + BAUD / 2 &&
             (last_pulse_cyc - t0) <= 9 * BAUD + BAUD / 2 + 4) ? 1 : 0, 1);

      // Back-to-back frames
      send_frame(8'hA5, 1'b1);
      send_frame(8'h3C, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_frame(8'h00, 1'b1);
      idle(20);
      check("b2b_pulses", npulse, 5);
      check("b2b_d0", {24'd0, rxd[1]}, 32'hA5);
      check("b2b_d1", {24'd0, rxd[2]}, 32'h3C);
      check("b2b_d2", {24'd0, rxd[3]}, 32'hFF);
      check("b2b_d3", {24'd0, rxd[4]}, 32'h00);

      // Glitch rejection then 0x81
      rx = 1'b0;
      repeat (10) @(posedge sclk);
      #1;
      idle(3 * BAUD);
      check("glitch_no_pulse", npulse, 5);
      send_frame(8'h81, 1'b1);
      idle(20);
      check("after_glitch_pulses", npulse, 6);
      check("after_glitch_data", {24'd0, rxd[5]}, 32'h81);

      // Framing error then 0x34
      send_frame(8'h12, 1'b0);
      idle(2 * BAUD);
      check("ferr_no_pulse", npulse, 6);
      check("ferr_data_held", {24'd0, rx_data}, 32'h81);
      send_frame(8'h34, 1'b1);
      idle(20);
      check("after_ferr_pulses", npulse, 7);
      check("after_ferr_data", {24'd0, rxd[6]}, 32'h34);

      // Reset during D3 of a 0x5A frame, then 0xC3
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      rx = 1'b1;
      repeat (BAUD / 2) @(posedge sclk);
      #1;
      srst = 1'b1;
      rx   = 1'b1;
      repeat (3) @(posedge sclk);
      #1;
      srst = 1'b0;
      idle(12 * BAUD);
      check("midrst_no_pulse", npulse, 7);
      check("midrst_data_zero", {24'd0, rx_data}, 32'h00);
      base = npulse;
      send_frame(8'hC3, 1'b1);
      idle(20);
      check("after_rst_pulses", npulse, base + 1);
      check("after_rst_data", {24'd0, rxd[7]}, 32'hC3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
